// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential req/gnt fetch, DEPTH-entry response FIFO, redirect flush.
// Optional FETCH_QUEUE_BYPASS_EN: a response arriving at an empty queue is presented combinationally.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc4_o,
    input  logic        inst_ready_i
);
    // state | meaning
    // IDLE  | not requesting; responses still outstanding land in the FIFO
    // FETCH | issuing sequential requests while count + outstanding < DEPTH
    // DRAIN | after a redirect, discarding stale responses before refetching
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW:0]    DEPTH_W = (CW+1)'(DEPTH);

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] aw_ptr_q, aw_ptr_d, ar_ptr_q, ar_ptr_d;
    logic [31:0]   inst_mem_q [DEPTH];
    logic [31:0]   pc4_mem_q  [DEPTH];
    logic [31:0]   addr_mem_q [DEPTH];

    logic          gnt_fire, rsp_fire, rsp_keep, rsp_drop;
    logic          flush, push, fifo_pop, bypass_take;
    logic [31:0]   rsp_pc4;
    logic [CW:0]   occupancy;

    assign occupancy  = {1'b0, count_q} + {1'b0, outst_q};
    assign mem_req_o  = (state_q == FETCH) && !redirect_i && (occupancy < DEPTH_W);
    assign mem_addr_o = fetch_pc_q;

    assign gnt_fire = mem_req_o && mem_gnt_i;
    assign rsp_fire = mem_rvalid_i && (outst_q != '0);
    assign rsp_drop = rsp_fire && (drop_q != '0);
    assign rsp_keep = rsp_fire && (drop_q == '0);
    assign flush    = redirect_i && (state_q != IDLE);
    // Request addresses are kept in issue order so each response knows its own PC.
    assign rsp_pc4  = addr_mem_q[ar_ptr_q] + 32'd4;

`ifdef FETCH_QUEUE_BYPASS_EN
    logic bypass;
    assign bypass       = (count_q == '0) && rsp_keep;
    assign bypass_take  = bypass && inst_ready_i;
    assign inst_valid_o = (count_q != '0) || bypass;
    assign inst_o       = bypass ? mem_rdata_i : inst_mem_q[rd_ptr_q];
    assign inst_pc4_o   = bypass ? rsp_pc4 : pc4_mem_q[rd_ptr_q];
`else
    assign bypass_take  = 1'b0;
    assign inst_valid_o = (count_q != '0);
    assign inst_o       = inst_mem_q[rd_ptr_q];
    assign inst_pc4_o   = pc4_mem_q[rd_ptr_q];
`endif

    assign fifo_pop = (count_q != '0) && inst_ready_i;
    assign push     = rsp_keep && !flush && !bypass_take;

    assign outst_d  = outst_q + CW'(gnt_fire) - CW'(rsp_fire);
    assign drop_d   = flush ? outst_d : (drop_q - CW'(rsp_drop));
    assign count_d  = flush ? '0 : (count_q + CW'(push) - CW'(fifo_pop));
    assign wr_ptr_d = flush ? '0 : (wr_ptr_q + AW'(push));
    assign rd_ptr_d = flush ? '0 : (rd_ptr_q + AW'(fifo_pop));
    assign aw_ptr_d = aw_ptr_q + AW'(gnt_fire);
    assign ar_ptr_d = ar_ptr_q + AW'(rsp_fire);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i & ~32'h3;
        end else if (gnt_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = FETCH;
            FETCH: begin
                if (redirect_i && (outst_d != '0)) state_d = DRAIN;
                else if (!start_i)                 state_d = IDLE;
            end
            DRAIN:   if (drop_d == '0) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            outst_q    <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            aw_ptr_q   <= '0;
            ar_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem_q[i] <= '0;
                pc4_mem_q[i]  <= '0;
                addr_mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            aw_ptr_q   <= aw_ptr_d;
            ar_ptr_q   <= ar_ptr_d;
            if (push) begin
                inst_mem_q[wr_ptr_q] <= mem_rdata_i;
                pc4_mem_q[wr_ptr_q]  <= rsp_pc4;
            end
            if (gnt_fire) begin
                addr_mem_q[aw_ptr_q] <= fetch_pc_q;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with random grant/latency and a program-order
// consumer model (expected PC stream restarted at every redirect target).
module tb_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i, start_i, redirect_i, mem_gnt_i, mem_rvalid_i, inst_ready_i;
    logic [31:0] redirect_pc_i, mem_rdata_i;
    logic        mem_req_o, inst_valid_o;
    logic [31:0] mem_addr_o, inst_o, inst_pc4_o;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc4_o(inst_pc4_o),
        .inst_ready_i(inst_ready_i)
    );

    always #5 clk = ~clk;

    int vectors, miscompares, cyc;
    // memory model: requests in flight with the cycle their response may return
    logic [31:0] mq_addr[$];
    int          mq_t[$];
    int          gnt_pct, lat_min, lat_max;
    bit          inject_spur;
    // consumer / fetch-address model
    logic [31:0] exp_fetch, exp_pc;
    int          live;
    bit          prev_req_wait, rd_prev;
    logic [31:0] prev_addr;
    // event records for scenario checks
    logic [31:0] g_addr[$], p_inst[$], p_pc4[$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic model_clear();
        mq_addr.delete(); mq_t.delete();
        exp_fetch = RESET_PC; exp_pc = RESET_PC; live = 0;
        prev_req_wait = 0; rd_prev = 0; inject_spur = 0;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        bit gnt, pop;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (inject_spur) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        end else if (mq_addr.size() > 0 && mq_t[0] <= cyc) begin
            mem_rvalid_i = 1'b1; mem_rdata_i = word(mq_addr[0]);
        end
        mem_gnt_i = ($urandom_range(99) < gnt_pct);
        #1;
        if (rd_prev) begin
            vectors++;
            if (inst_valid_o !== 1'b0) begin
                miscompares++; $display("FAIL valid_after_redirect: got %b want 0", inst_valid_o);
            end
        end
        if (redirect_i) begin
            vectors++;
            if (mem_req_o !== 1'b0) begin
                miscompares++; $display("FAIL req_masked_on_redirect: got %b want 0", mem_req_o);
            end
        end
        if (prev_req_wait && !redirect_i) begin
            vectors++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
                miscompares++;
                $display("FAIL req_hold: got req %b addr %h want req 1 addr %h", mem_req_o, mem_addr_o, prev_addr);
            end
        end
        gnt = mem_req_o && mem_gnt_i;
        pop = inst_valid_o && inst_ready_i;
        if (gnt) begin
            vectors++;
            if (mem_addr_o !== exp_fetch) begin
                miscompares++; $display("FAIL grant_addr: got %h want %h", mem_addr_o, exp_fetch);
            end
            g_addr.push_back(mem_addr_o);
        end
        if (pop) begin
            vectors++;
            if (inst_o !== word(exp_pc) || inst_pc4_o !== exp_pc + 32'd4) begin
                miscompares++;
                $display("FAIL pop_stream: got inst %h pc4 %h want inst %h pc4 %h",
                         inst_o, inst_pc4_o, word(exp_pc), exp_pc + 32'd4);
            end
            p_inst.push_back(inst_o); p_pc4.push_back(inst_pc4_o);
        end
        if (mem_rvalid_i && !inject_spur) begin
            void'(mq_addr.pop_front()); void'(mq_t.pop_front());
        end
        inject_spur = 0;
        if (gnt) begin
            mq_addr.push_back(mem_addr_o);
            mq_t.push_back(cyc + $urandom_range(lat_max, lat_min));
            exp_fetch = exp_fetch + 32'd4;
            live++;
        end
        if (pop) begin
            exp_pc = exp_pc + 32'd4;
            live--;
        end
        if (redirect_i) begin
            exp_fetch = redirect_pc_i & ~32'h3;
            exp_pc    = redirect_pc_i & ~32'h3;
            live      = 0;
        end
        vectors++;
        if (live > DEPTH || live < 0) begin
            miscompares++; $display("FAIL occupancy_cap: got %0d live want 0..%0d", live, DEPTH);
        end
        prev_req_wait = mem_req_o && !mem_gnt_i && start_i && !redirect_i;
        prev_addr     = mem_addr_o;
        rd_prev       = redirect_i;
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        inst_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_clear();
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
    endtask

    task automatic set_mem(input int pct, input int lmin, input int lmax);
        gnt_pct = pct; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; start_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        inst_ready_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        model_clear(); set_mem(100, 1, 1);
        @(negedge clk); #1;
        vectors += 5;
        if (mem_req_o !== 1'b0)     begin miscompares++; $display("FAIL reset_req: got %b want 0", mem_req_o); end
        if (mem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL reset_addr: got %h want %h", mem_addr_o, RESET_PC); end
        if (inst_valid_o !== 1'b0)  begin miscompares++; $display("FAIL reset_valid: got %b want 0", inst_valid_o); end
        if (inst_o !== 32'h0)       begin miscompares++; $display("FAIL reset_inst: got %h want 0", inst_o); end
        if (inst_pc4_o !== 32'h0)   begin miscompares++; $display("FAIL reset_pc4: got %h want 0", inst_pc4_o); end
        @(negedge clk);
        rst_i = 1'b1;
        cycle();
        vectors++;
        if (mem_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req: got %b want 0", mem_req_o); end
        // redirect while idle only moves the fetch address
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0202;
        cycle();
        redirect_i = 1'b0; start_i = 1'b1; g_addr.delete();
        for (int n = 0; n < 10 && g_addr.size() == 0; n++) cycle();
        vectors++;
        if (g_addr.size() == 0 || g_addr[0] !== 32'h0000_0200) begin
            miscompares++; $display("FAIL idle_redirect_addr: got %h want 00000200", g_addr.size() ? g_addr[0] : 32'hx);
        end
    endtask

    task automatic test_stream();
        int p0;
        do_reset(); set_mem(100, 1, 1);
        start_i = 1'b1; inst_ready_i = 1'b1;
        g_addr.delete(); p_pc4.delete();
        repeat (10) cycle();
        vectors++;
        if (g_addr.size() < 3 || g_addr[0] !== 32'h0 || g_addr[1] !== 32'h4 || g_addr[2] !== 32'h8) begin
            miscompares++; $display("FAIL stream_addrs: got %0d grants first %h want 0,4,8", g_addr.size(), g_addr.size() ? g_addr[0] : 32'hx);
        end
        vectors++;
        if (p_pc4.size() < 3 || p_pc4[0] !== 32'h4 || p_pc4[1] !== 32'h8 || p_pc4[2] !== 32'hC) begin
            miscompares++; $display("FAIL stream_pc4: got %0d pops first %h want 4,8,c", p_pc4.size(), p_pc4.size() ? p_pc4[0] : 32'hx);
        end
        p0 = p_pc4.size();
        repeat (20) cycle();
        vectors++;
        if (p_pc4.size() - p0 != 20) begin
            miscompares++; $display("FAIL stream_rate: got %0d pops in 20 cycles want 20", p_pc4.size() - p0);
        end
    endtask

    task automatic test_stall();
        inst_ready_i = 1'b0;
        repeat (10) cycle();
        vectors++;
        if (live != DEPTH) begin
            miscompares++; $display("FAIL stall_fill: got %0d buffered want %0d", live, DEPTH);
        end
        inst_ready_i = 1'b1; p_pc4.delete();
        repeat (6) cycle();
        vectors++;
        if (p_pc4.size() < 4) begin
            miscompares++; $display("FAIL stall_release: got %0d pops want >=4", p_pc4.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                vectors++;
                if (p_pc4[i+1] !== p_pc4[i] + 32'd4) begin
                    miscompares++; $display("FAIL stall_order: got %h after %h want %h", p_pc4[i+1], p_pc4[i], p_pc4[i] + 32'd4);
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(); set_mem(100, 3, 3);
        start_i = 1'b1; inst_ready_i = 1'b1;
        repeat (8) cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
        cycle();
        redirect_i = 1'b0;
        g_addr.delete(); p_inst.delete(); p_pc4.delete();
        for (int n = 0; n < 30 && (g_addr.size() == 0 || p_pc4.size() == 0); n++) cycle();
        vectors += 3;
        if (g_addr.size() == 0 || g_addr[0] !== 32'h0000_0100) begin
            miscompares++; $display("FAIL redirect_addr: got %h want 00000100", g_addr.size() ? g_addr[0] : 32'hx);
        end
        if (p_inst.size() == 0 || p_inst[0] !== word(32'h100)) begin
            miscompares++; $display("FAIL redirect_inst: got %h want %h", p_inst.size() ? p_inst[0] : 32'hx, word(32'h100));
        end
        if (p_pc4.size() == 0 || p_pc4[0] !== 32'h0000_0104) begin
            miscompares++; $display("FAIL redirect_pc4: got %h want 00000104", p_pc4.size() ? p_pc4[0] : 32'hx);
        end
    endtask

    task automatic test_redirect_pop();
        bit found = 0;
        do_reset(); set_mem(100, 1, 1);
        start_i = 1'b1; inst_ready_i = 1'b0;
        repeat (6) cycle();
        inst_ready_i = 1'b1;
        for (int n = 0; n < 40 && !found; n++) begin
            if (inst_valid_o === 1'b1 && inst_pc4_o === 32'h20) found = 1;
            else cycle();
        end
        vectors++;
        if (!found) begin
            miscompares++; $display("FAIL redirect_pop_setup: got no head with pc4 00000020 want one");
        end
        redirect_i = 1'b1; redirect_pc_i = 32'h0000_0300; p_pc4.delete();
        cycle();
        redirect_i = 1'b0;
        vectors += 2;
        if (p_pc4.size() != 1 || p_pc4[0] !== 32'h20) begin
            miscompares++; $display("FAIL redirect_pop_honoured: got %0d pops pc4 %h want 1 pop 00000020", p_pc4.size(), p_pc4.size() ? p_pc4[0] : 32'hx);
        end
        if (inst_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL redirect_pop_flush: got valid %b want 0", inst_valid_o);
        end
        repeat (10) cycle();
    endtask

    task automatic test_wrap();
        do_reset(); set_mem(100, 1, 1);
        start_i = 1'b1; inst_ready_i = 1'b1;
        repeat (3) cycle();
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        redirect_i = 1'b0; g_addr.delete(); p_pc4.delete();
        for (int n = 0; n < 30 && (g_addr.size() < 3 || p_pc4.size() < 3); n++) cycle();
        vectors += 2;
        if (g_addr.size() < 3 || g_addr[0] !== 32'hFFFF_FFF8 || g_addr[1] !== 32'hFFFF_FFFC || g_addr[2] !== 32'h0) begin
            miscompares++; $display("FAIL wrap_addrs: got %0d grants third %h want fffffff8,fffffffc,00000000", g_addr.size(), g_addr.size() > 2 ? g_addr[2] : 32'hx);
        end
        if (p_pc4.size() < 3 || p_pc4[0] !== 32'hFFFF_FFFC || p_pc4[1] !== 32'h0 || p_pc4[2] !== 32'h4) begin
            miscompares++; $display("FAIL wrap_pc4: got %0d pops second %h want fffffffc,00000000,00000004", p_pc4.size(), p_pc4.size() > 1 ? p_pc4[1] : 32'hx);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        do_reset(); set_mem(100, 6, 6);
        start_i = 1'b1; inst_ready_i = 1'b0;
        while (!(mq_addr.size() == 1 && live == DEPTH) && n < 30) begin cycle(); n++; end
        vectors++;
        if (!(mq_addr.size() == 1 && live == DEPTH)) begin
            miscompares++; $display("FAIL areset_setup: got %0d in flight %0d buffered want 1 and %0d", mq_addr.size(), live, DEPTH);
        end
        #2 rst_i = 1'b0;
        #1;
        vectors += 5;
        if (mem_req_o !== 1'b0)      begin miscompares++; $display("FAIL areset_req: got %b want 0", mem_req_o); end
        if (mem_addr_o !== RESET_PC) begin miscompares++; $display("FAIL areset_addr: got %h want %h", mem_addr_o, RESET_PC); end
        if (inst_valid_o !== 1'b0)   begin miscompares++; $display("FAIL areset_valid: got %b want 0", inst_valid_o); end
        if (inst_o !== 32'h0)        begin miscompares++; $display("FAIL areset_inst: got %h want 0", inst_o); end
        if (inst_pc4_o !== 32'h0)    begin miscompares++; $display("FAIL areset_pc4: got %h want 0", inst_pc4_o); end
        @(negedge clk);
        rst_i = 1'b1; start_i = 1'b0; inst_ready_i = 1'b1;
        model_clear();
        inject_spur = 1;
        cycle();
        cycle();
        vectors++;
        if (inst_valid_o !== 1'b0) begin
            miscompares++; $display("FAIL late_rvalid_ignored: got valid %b want 0", inst_valid_o);
        end
        start_i = 1'b1; set_mem(100, 1, 1); g_addr.delete();
        for (int k = 0; k < 10 && g_addr.size() == 0; k++) cycle();
        vectors++;
        if (g_addr.size() == 0 || g_addr[0] !== RESET_PC) begin
            miscompares++; $display("FAIL restart_addr: got %h want %h", g_addr.size() ? g_addr[0] : 32'hx, RESET_PC);
        end
    endtask

    task automatic test_random();
        logic last;
        int   n = 0;
        do_reset(); set_mem(60, 1, 4);
        start_i = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            last         = start_i;
            start_i      = ($urandom_range(99) < 93);
            inst_ready_i = ($urandom_range(99) < 70);
            redirect_i   = start_i && last && ($urandom_range(99) < 4);
            if (redirect_i)
                redirect_pc_i = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cycle();
        end
        redirect_i = 1'b0; start_i = 1'b0; inst_ready_i = 1'b1; set_mem(100, 1, 4);
        while ((live != 0 || mq_addr.size() != 0) && n < 100) begin cycle(); n++; end
        vectors++;
        if (live != 0 || mq_addr.size() != 0) begin
            miscompares++; $display("FAIL random_drain: got %0d undelivered %0d in flight want 0", live, mq_addr.size());
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
